apb_slave_regfile: RTL and testbench

APB completer that answers the master-side transfers driven on the APB interface. It decodes one PSEL bit, inserts a programmable number of wait states, and returns PREADY as a single-cycle registered pulse, so the master's rising-edge wait on PREADY always fires. Behind it sits a word-addressed register file of NUM_REGS entries. It serves as the DUT-side responder in the APB VIP bench and as the slave model for multi-slave PSEL decode tests.

---
 rtl/apb_pkg.sv | 14 +
 rtl/apb_regfile.sv | 27 ++
 rtl/apb_slave_regfile.sv | 105 ++++++++++
 tb/tb_apb_slave_regfile.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB completer and its register file.
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

package apb_pkg;
    localparam int IDX_LSB = 2;
    typedef enum logic [1:0] {IDLE, SETUP, WAIT, RESP} apb_slv_state_e;
    typedef logic [`D_DATA_WIDTH-1:0] apb_data_t;
    typedef logic [`D_ADDR_WIDTH-1:0] apb_addr_t;
endpackage

// File: rtl/apb_regfile.sv
// apb_regfile: word array with synchronous write and combinational read.
module apb_regfile #(
    parameter int NUM_REGS = 16,
    parameter int DATA_WIDTH = 32,
    parameter int IW = $clog2(NUM_REGS),
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IW-1:0]         widx,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [IW-1:0]         ridx,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= RESET_VAL;
        end else if (we) begin
            mem[widx] <= wdata;
        end
    end

    assign rdata = mem[ridx];
endmodule

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer with programmable wait states and a one-cycle
// registered PREADY pulse in front of a word-addressed register file.
`ifndef D_ADDR_WIDTH
`define D_ADDR_WIDTH 32
`endif
`ifndef D_DATA_WIDTH
`define D_DATA_WIDTH 32
`endif

module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = `D_ADDR_WIDTH,
    parameter int DATA_WIDTH = `D_DATA_WIDTH,
    parameter int NUM_REGS = 16,
    parameter int WAIT_STATES = 1,
    parameter logic [DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  o_addr_err
);
    localparam int IW = $clog2(NUM_REGS);
    localparam logic [3:0] CNT_INIT = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    apb_slv_state_e state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [IW-1:0] idx_q;
    logic oor_q, write_q, we;
    logic [DATA_WIDTH-1:0] wdata_q, rdata;

    // Writes commit on the RESP exit edge, so a following read sees them.
    assign we = state == RESP && write_q && !oor_q;

    apb_regfile #(
        .NUM_REGS(NUM_REGS),
        .DATA_WIDTH(DATA_WIDTH),
        .IW(IW),
        .RESET_VAL(RESET_VAL)
    ) u_regs (
        .clk(PCLK),
        .rst(PRESET),
        .we(we),
        .widx(idx_q),
        .wdata(wdata_q),
        .ridx(idx_q),
        .rdata(rdata)
    );

    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE:  state_n = (PSEL && !PENABLE) ? SETUP : IDLE;
            SETUP: begin
                if (!PSEL) begin
                    state_n = IDLE;
                end else if (PENABLE) begin
                    state_n = (WAIT_STATES > 0) ? WAIT : RESP;
                    cnt_n = CNT_INIT;
                end
            end
            WAIT: begin
                if (!PSEL || !PENABLE) state_n = IDLE;
                else if (cnt == 4'd0) state_n = RESP;
                else cnt_n = cnt - 4'd1;
            end
            RESP:    state_n = (PSEL && !PENABLE) ? SETUP : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            cnt <= 4'd0;
            PREADY <= 1'b0;
            PRDATA <= '0;
            o_addr_err <= 1'b0;
            idx_q <= '0;
            oor_q <= 1'b0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            PREADY <= state_n == RESP;
            if (state_n == SETUP) begin
                idx_q <= PADDR[IDX_LSB +: IW];
                oor_q <= |(PADDR >> (IDX_LSB + IW));
                write_q <= PWRITE;
                wdata_q <= PWDATA;
            end
            if (state_n == RESP && !write_q) PRDATA <= oor_q ? '0 : rdata;
            if (state_n == RESP && oor_q) o_addr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb_apb_slave_regfile: four completers on one bus (wait states 1, 0, 3, 15),
// checked against an array model of the register files.
module tb_apb_slave_regfile;
    localparam logic [31:0] RV0 = 32'h5A5A_0F0F;

    logic PCLK = 0, PRESET = 1, PENABLE = 0, PWRITE = 0;
    logic [31:0] PADDR = 0, PWDATA = 0;
    logic [3:0] psel = 0, pready, err;
    logic [31:0] prdata [4];
    int ws [4] = '{1, 0, 3, 15};
    logic [31:0] mem [4][16];
    logic exp_err [4];
    logic [31:0] last_rd [4];
    int checks = 0, failures = 0;

    always #5 PCLK = ~PCLK;

    apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(1), .RESET_VAL(RV0)) u_s0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(pready[0]), .PRDATA(prdata[0]), .o_addr_err(err[0]));
    apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(0), .RESET_VAL(32'h0)) u_s1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(pready[1]), .PRDATA(prdata[1]), .o_addr_err(err[1]));
    apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(3), .RESET_VAL(32'h0)) u_s2 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[2]), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(pready[2]), .PRDATA(prdata[2]), .o_addr_err(err[2]));
    apb_slave_regfile #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .WAIT_STATES(15), .RESET_VAL(32'h0)) u_s3 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[3]), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PREADY(pready[3]), .PRDATA(prdata[3]), .o_addr_err(err[3]));

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 16; i++) mem[s][i] = (s == 0) ? RV0 : 32'h0;
            exp_err[s] = 0;
            last_rd[s] = 32'h0;
        end
    endtask

    // A transfer completes; reads of out-of-range words return 0, writes keep PRDATA.
    task automatic model_xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] exp_rd);
        logic oor;
        int idx;
        oor = |a[31:6];
        idx = int'(a[5:2]);
        if (oor) exp_err[s] = 1;
        if (wr) begin
            if (!oor) mem[s][idx] = d;
            exp_rd = last_rd[s];
        end else begin
            exp_rd = oor ? 32'h0 : mem[s][idx];
        end
        last_rd[s] = exp_rd;
    endtask

    task automatic do_reset(input int n);
        PRESET = 1;
        psel = 0;
        PENABLE = 0;
        repeat (n) @(posedge PCLK);
        #1 PRESET = 0;
        model_reset();
    endtask

    // lat counts edges from the one sampling PENABLE to the one raising PREADY.
    task automatic xfer(input int s, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int lat, output logic after, output logic others);
        psel = 4'(1 << s);
        PENABLE = 0;
        PWRITE = wr;
        PADDR = a;
        PWDATA = d;
        @(posedge PCLK);
        #1 PENABLE = 1;
        lat = -1;
        rd = 32'h0;
        others = 0;
        for (int n = 1; n <= 40 && lat < 0; n++) begin
            @(posedge PCLK);
            #1;
            others |= |(pready & ~psel);
            if (pready[s]) begin
                lat = n;
                rd = prdata[s];
            end else begin
                PADDR = $urandom;
                PWDATA = $urandom;
            end
        end
        psel = 0;
        PENABLE = 0;
        @(posedge PCLK);
        #1 after = pready[s];
    endtask

    task automatic test_reset();
        logic [31:0] rd, exp;
        int lat;
        logic after, others;
        do_reset(2);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (pready[s] !== 1'b0 || prdata[s] !== 32'h0 || err[s] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs s%0d: pready=%b prdata=%h err=%b, want 0/0/0", s, pready[s], prdata[s], err[s]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            xfer(0, 0, 32'(i * 4), $urandom, rd, lat, after, others);
            model_xfer(0, 0, 32'(i * 4), 32'h0, exp);
            checks++;
            if (rd !== RV0) begin
                failures++;
                $display("FAIL reset_read idx%0d: got %h want %h", i, rd, RV0);
            end
            checks++;
            if (lat !== 2 || after !== 1'b0) begin
                failures++;
                $display("FAIL reset_pulse idx%0d: lat=%0d after=%b want 2/0", i, lat, after);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] rd, exp;
        int lat;
        logic after, others;
        xfer(0, 1, 32'h0C, 32'hDEADBEEF, rd, lat, after, others);
        model_xfer(0, 1, 32'h0C, 32'hDEADBEEF, exp);
        checks++;
        if (rd !== exp || lat !== 2 || after !== 1'b0) begin
            failures++;
            $display("FAIL wr_0c: prdata=%h lat=%0d after=%b want %h/2/0", rd, lat, after, exp);
        end
        xfer(0, 0, 32'h0C, 32'h0, rd, lat, after, others);
        model_xfer(0, 0, 32'h0C, 32'h0, exp);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_0c: got %h want deadbeef", rd);
        end
        checks++;
        if (lat !== 2 || after !== 1'b0) begin
            failures++;
            $display("FAIL rd_0c_timing: lat=%0d after=%b want 2/0", lat, after);
        end
    endtask

    task automatic test_wait_sweep();
        logic [31:0] rd, exp, d, a;
        int lat;
        logic after, others;
        for (int s = 1; s < 4; s++) begin
            d = $urandom;
            a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            xfer(s, 1, a, d, rd, lat, after, others);
            model_xfer(s, 1, a, d, exp);
            checks++;
            if (lat !== 1 + ws[s] || after !== 1'b0) begin
                failures++;
                $display("FAIL sweep_wr ws%0d: lat=%0d after=%b want %0d/0", ws[s], lat, after, 1 + ws[s]);
            end
            xfer(s, 0, a, 32'h0, rd, lat, after, others);
            model_xfer(s, 0, a, 32'h0, exp);
            checks++;
            if (lat !== 1 + ws[s] || after !== 1'b0 || rd !== d) begin
                failures++;
                $display("FAIL sweep_rd ws%0d: lat=%0d after=%b data=%h want %0d/0/%h", ws[s], lat, after, rd, 1 + ws[s], d);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, exp;
        int lat;
        logic after, others;
        xfer(0, 1, 32'h40, 32'h1234, rd, lat, after, others);
        model_xfer(0, 1, 32'h40, 32'h1234, exp);
        checks++;
        if (lat !== 2 || err[0] !== 1'b1 || err[1] !== exp_err[1]) begin
            failures++;
            $display("FAIL oor_wr: lat=%0d err0=%b err1=%b want 2/1/%b", lat, err[0], err[1], exp_err[1]);
        end
        xfer(0, 0, 32'h40, 32'h0, rd, lat, after, others);
        model_xfer(0, 0, 32'h40, 32'h0, exp);
        checks++;
        if (rd !== 32'h0 || lat !== 2) begin
            failures++;
            $display("FAIL oor_rd: data=%h lat=%0d want 0/2", rd, lat);
        end
        xfer(0, 0, 32'h0, 32'h0, rd, lat, after, others);
        model_xfer(0, 0, 32'h0, 32'h0, exp);
        checks++;
        if (rd !== RV0 || err[0] !== 1'b1) begin
            failures++;
            $display("FAIL oor_reg0: data=%h err=%b want %h/1", rd, err[0], RV0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int n1, n2;
        n1 = -1;
        n2 = -1;
        psel = 4'b0001;
        PENABLE = 0;
        PWRITE = 1;
        PADDR = 32'h08;
        PWDATA = 32'hA5;
        @(posedge PCLK);
        #1 PENABLE = 1;
        for (int n = 1; n <= 40 && n1 < 0; n++) begin
            @(posedge PCLK);
            #1 if (pready[0]) n1 = n;
        end
        model_xfer(0, 1, 32'h08, 32'hA5, exp);
        PENABLE = 0;
        PWRITE = 0;
        PWDATA = 32'h0;
        @(posedge PCLK);
        #1;
        checks++;
        if (n1 !== 2 || pready[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d pready_after=%b want 2/0", n1, pready[0]);
        end
        PENABLE = 1;
        for (int n = 1; n <= 40 && n2 < 0; n++) begin
            @(posedge PCLK);
            #1 if (pready[0]) n2 = n;
        end
        model_xfer(0, 0, 32'h08, 32'h0, exp);
        checks++;
        if (n2 !== 2 || prdata[0] !== 32'hA5) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d data=%h want 2/000000a5", n2, prdata[0]);
        end
        psel = 0;
        PENABLE = 0;
        @(posedge PCLK);
        #1;
        checks++;
        if (pready[0] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_width: pready=%b want 0", pready[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, exp, old;
        int lat;
        logic after, others, seen;
        old = mem[2][5];
        psel = 4'b0100;
        PENABLE = 0;
        PWRITE = 1;
        PADDR = 32'h14;
        PWDATA = ~old;
        @(posedge PCLK);
        #1 PENABLE = 1;
        @(posedge PCLK);
        #1 psel = 0;
        PENABLE = 0;
        seen = 0;
        repeat (20) begin
            @(posedge PCLK);
            #1 seen |= |pready;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL abort_pready: saw %b want 0", seen);
        end
        xfer(2, 0, 32'h14, 32'h0, rd, lat, after, others);
        model_xfer(2, 0, 32'h14, 32'h0, exp);
        checks++;
        if (rd !== old) begin
            failures++;
            $display("FAIL abort_reg: got %h want %h", rd, old);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, exp;
        int lat;
        logic after, others, seen;
        xfer(3, 1, 32'h1C, 32'hCAFEF00D, rd, lat, after, others);
        model_xfer(3, 1, 32'h1C, 32'hCAFEF00D, exp);
        psel = 4'b1000;
        PENABLE = 0;
        PWRITE = 1;
        PADDR = 32'h1C;
        PWDATA = 32'h11112222;
        @(posedge PCLK);
        #1 PENABLE = 1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1;
        seen = 0;
        repeat (2) begin
            @(posedge PCLK);
            #1 seen |= |pready;
        end
        PRESET = 0;
        psel = 0;
        PENABLE = 0;
        model_reset();
        repeat (20) begin
            @(posedge PCLK);
            #1 seen |= |pready;
        end
        checks++;
        if (seen !== 1'b0 || prdata[3] !== 32'h0 || err !== 4'b0) begin
            failures++;
            $display("FAIL midreset_outputs: pready_seen=%b prdata=%h err=%b want 0/0/0", seen, prdata[3], err);
        end
        xfer(3, 0, 32'h1C, 32'h0, rd, lat, after, others);
        model_xfer(3, 0, 32'h1C, 32'h0, exp);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL midreset_reg3: got %h want 0", rd);
        end
        xfer(0, 0, 32'h08, 32'h0, rd, lat, after, others);
        model_xfer(0, 0, 32'h08, 32'h0, exp);
        checks++;
        if (rd !== RV0) begin
            failures++;
            $display("FAIL midreset_reg0: got %h want %h", rd, RV0);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp, a, d;
        logic [25:0] up;
        logic wr, after, others;
        int s, lat;
        for (int it = 0; it < 80; it++) begin
            s = $urandom_range(0, 3);
            wr = 1'($urandom_range(0, 1));
            up = ($urandom_range(0, 7) == 0) ? 26'($urandom_range(1, 26'h3FFFFFF)) : 26'h0;
            a = {up, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            d = $urandom;
            xfer(s, wr, a, d, rd, lat, after, others);
            model_xfer(s, wr, a, d, exp);
            checks++;
            if (rd !== exp) begin
                failures++;
                $display("FAIL rand_data it%0d s%0d wr%b a=%h: got %h want %h", it, s, wr, a, rd, exp);
            end
            checks++;
            if (lat !== 1 + ws[s] || after !== 1'b0 || others !== 1'b0) begin
                failures++;
                $display("FAIL rand_timing it%0d s%0d: lat=%0d after=%b others=%b want %0d/0/0", it, s, lat, after, others, 1 + ws[s]);
            end
            checks++;
            if (err[s] !== exp_err[s]) begin
                failures++;
                $display("FAIL rand_err it%0d s%0d: got %b want %b", it, s, err[s], exp_err[s]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_readback();
        test_wait_sweep();
        test_out_of_range();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
